seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 38 +++
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_muldiv.sv | 81 ++++++++
 rtl/seq_alu.sv | 128 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU and its
// iterative multiply/divide unit.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SLL  = 4'b0011,
      OP_SRL  = 4'b0100,
      OP_SRA  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SLT  = 4'b0111,
      OP_SLTU = 4'b1000,
      OP_XOR  = 4'b1001,
      OP_NOR  = 4'b1010,
      OP_MUL  = 4'b1011,
      OP_DIVU = 4'b1100,
      OP_REMU = 4'b1101,
      OP_RSV0 = 4'b1110,
      OP_RSV1 = 4'b1111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic isMulDiv(input op_e op);
      return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

   function automatic logic isDiv(input op_e op);
      return (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle of seq_alu; master issues operations,
// slave (the ALU) returns results.
interface seq_alu_if #(
   parameter int W  = 32,
   parameter int SW = $clog2(W)
);
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [3:0]    op;
   logic [SW-1:0] shamt;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          zero;
   logic          overflow;
   logic          busy;

   modport master (
      output in_valid, a, b, op, shamt, out_ready,
      input  in_ready, out_valid, result, zero, overflow, busy
   );

   modport slave (
      input  in_valid, a, b, op, shamt, out_ready,
      output in_ready, out_valid, result, zero, overflow, busy
   );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative W-step shift-add multiplier and restoring divider. done is high
// during the final iteration, with result showing the value that iteration produces.
module seq_muldiv
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  op_e          op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] result
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic          running_q;
   logic [CW-1:0] cnt_q;
   op_e           opSel_q;
   logic [W-1:0]  acc_q, mcand_q, mplier_q;
   logic [W-1:0]  acc_d, mcand_d, mplier_d;
   logic [W:0]    remShift, trial;

   // acc holds product or partial remainder; mplier doubles as dividend/quotient shifter.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      remShift = {acc_q, mplier_q[W-1]};
      trial    = remShift - {1'b0, mcand_q};
      if (opSel_q == OP_MUL) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end else if (!trial[W]) begin
         acc_d    = trial[W-1:0];
         mplier_d = {mplier_q[W-2:0], 1'b1};
      end else begin
         acc_d    = remShift[W-1:0];
         mplier_d = {mplier_q[W-2:0], 1'b0};
      end
   end

   assign done   = running_q && (cnt_q == LAST);
   assign result = (opSel_q == OP_DIVU) ? mplier_d : acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
         opSel_q   <= OP_AND;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
      end else if (start) begin
         running_q <= 1'b1;
         cnt_q     <= '0;
         opSel_q   <= op;
         acc_q     <= '0;
         mcand_q   <= b;
         mplier_q  <= a;
      end else if (running_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         if (cnt_q == LAST) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops with a registered result,
// plus multi-cycle MUL/DIVU/REMU sequenced through an IDLE/RUN/DONE FSM.
module seq_alu
   import alu_pkg::*;
#(
   parameter int W  = 32,
   parameter int SW = $clog2(W)
) (
   input logic      clk,
   input logic      rst_n,
   seq_alu_if.slave bus
);

   state_e       state_q;
   logic         out_valid_q, zero_q, overflow_q;
   logic [W-1:0] result_q;

   op_e          opc;
   logic         busy, inReady, accept, divZero, mdStart, mdDone;
   logic [W-1:0] mdResult, sum, diff, dzRes, aluRes_d;
   logic         aluOvf_d;

   assign opc     = op_e'(bus.op);
   assign busy    = (state_q != S_IDLE);
   assign inReady = !busy && (!out_valid_q || bus.out_ready);
   assign accept  = bus.in_valid && inReady;
   assign divZero = isDiv(opc) && (bus.b == '0);
   assign mdStart = accept && isMulDiv(opc) && !divZero;
   assign dzRes   = (opc == OP_DIVU) ? '1 : bus.a;
   assign sum     = bus.a + bus.b;
   assign diff    = bus.a - bus.b;

   always_comb begin
      aluRes_d = '0;
      aluOvf_d = 1'b0;
      case (opc)
         OP_AND:  aluRes_d = bus.a & bus.b;
         OP_OR:   aluRes_d = bus.a | bus.b;
         OP_XOR:  aluRes_d = bus.a ^ bus.b;
         OP_NOR:  aluRes_d = ~(bus.a | bus.b);
         OP_ADD: begin
            aluRes_d = sum;
            aluOvf_d = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
         end
         OP_SUB: begin
            aluRes_d = diff;
            aluOvf_d = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
         end
         OP_SLL:  aluRes_d = bus.a << bus.shamt;
         OP_SRL:  aluRes_d = bus.a >> bus.shamt;
         OP_SRA:  aluRes_d = $unsigned($signed(bus.a) >>> bus.shamt);
         OP_SLT:  aluRes_d = {{(W-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         OP_SLTU: aluRes_d = {{(W-1){1'b0}}, bus.a < bus.b};
         default: aluRes_d = '0;
      endcase
   end

   seq_muldiv #(.W(W)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mdStart),
      .op     (opc),
      .a      (bus.a),
      .b      (bus.b),
      .done   (mdDone),
      .result (mdResult)
   );

   // A result sits in the output register until handshaked; a new single-cycle
   // accept may replace it in the same cycle it is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept && isMulDiv(opc)) begin
                  overflow_q <= 1'b0;
                  if (divZero) begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= dzRes;
                     zero_q      <= (dzRes == '0);
                  end else begin
                     state_q     <= S_RUN;
                     out_valid_q <= 1'b0;
                  end
               end else if (accept) begin
                  out_valid_q <= 1'b1;
                  result_q    <= aluRes_d;
                  zero_q      <= (aluRes_d == '0);
                  overflow_q  <= aluOvf_d;
               end else if (out_valid_q && bus.out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            S_RUN: begin
               if (mdDone) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= mdResult;
                  zero_q      <= (mdResult == '0);
                  overflow_q  <= 1'b0;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = overflow_q;
   assign bus.busy      = busy;

endmodule
